mc_alu: RTL and testbench
=========================

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width (legal range 8..64).
REQ-002 Parameter OP_W, default 4, SHALL set the opcode width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL qualify a, b and op.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a new operation.
REQ-007 a, b  input  WIDTH each  SHALL be the operands.
REQ-008 op  input  OP_W  SHALL select the operation (REQ-012).
REQ-009 out_valid  output  1  SHALL qualify y and the flags.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-011 y  output  WIDTH, zero/carry/ovf/err  output  1 each  SHALL be the registered result and flags.

Function
REQ-012 Opcodes SHALL be: 0 PASSB, 1 SLTU, 2 ADD, 3 SUB, 4 PASSA, 5 MUL, 6 EQ, 7 AND, 8 OR, 9 XOR, 10 SLT (signed), 11 DIVU, 12 REMU; 13..15 are illegal.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 An operation is accepted on in_valid && in_ready; the operands and op are latched.
REQ-015 Single-cycle ops (all except MUL/DIVU/REMU) SHALL go IDLE->DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-016 MUL/DIVU/REMU SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-017 In DONE, y and the flags SHALL hold stable while out_ready is 0; out_ready=1 SHALL return the FSM to IDLE on that edge.
REQ-018 A new accept SHALL NOT be possible in the DONE cycle (throughput is at most one op per 2 cycles).
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-020 carry SHALL be the carry-out for ADD and the no-borrow bit for SUB (a + ~b + 1).
REQ-021 ovf SHALL be set on signed overflow for ADD/SUB; carry and ovf SHALL be 0 for all other ops.
REQ-022 MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-023 SLTU/SLT SHALL return 1 or 0, zero-extended to WIDTH.
REQ-024 EQ SHALL return y=0 with zero=(a==b); for all other ops, zero=(y==0).
REQ-025 DIVU with b=0 SHALL return all-ones; REMU with b=0 SHALL return a; both SHALL set err=1.
REQ-026 An illegal op SHALL complete in 1 cycle with y=0 and err=1.
REQ-027 Operand changes on a/b/op while in BUSY or DONE SHALL have no effect.

Reset
REQ-028 While rst_n=0: state=IDLE, out_valid=0, y=0, all flags 0, iteration counter=0; in_ready=1 from the first edge after release.
REQ-029 A reset asserted in BUSY or DONE SHALL abort the operation and produce no out_valid.

Configuration
REQ-030 Macro MC_ALU_DIV_EN defined: DIVU/REMU SHALL be implemented per REQ-016/REQ-025.
REQ-031 Macro MC_ALU_DIV_EN undefined: opcodes 11/12 SHALL be treated as illegal (REQ-026), and no divider logic SHALL be synthesised.

Structure
REQ-032 Package mc_alu_pkg SHALL hold the opcode enum, the FSM state typedef and the ALU_LAT_1 constant.
REQ-033 Sub-module mc_alu_iter SHALL implement the shift-add multiplier and the restoring divider, with start/done ports and a WIDTH-cycle counter.
REQ-034 The top level SHALL hold the FSM, the single-cycle datapath and the output registers.

Verification (WIDTH=32)
REQ-035 ADD a=0x7FFFFFFF, b=1 -> after 1 cycle y=0x80000000, ovf=1, carry=0, zero=0.
REQ-036 SUB a=5, b=5 -> y=0, zero=1, carry=1; EQ a=9, b=9 -> y=0, zero=1.
REQ-037 MUL a=0x10000, b=0x10001, with out_ready held 0 for 3 cycles -> out_valid at cycle 33, y=0x00010000 stable until out_ready.
REQ-038 DIVU a=100, b=7 -> y=14; REMU -> y=2; DIVU b=0 -> y=0xFFFFFFFF, err=1; with the macro off -> y=0, err=1 after 1 cycle.
REQ-039 SLT a=0xFFFFFFFF, b=1 -> y=1; SLTU with the same operands -> y=0; op=15 -> y=0, err=1.
REQ-040 rst_n pulsed low at cycle 10 of a MUL -> no out_valid, in_ready=1 after release; the next ADD 2+3 gives y=5.

Source files
------------

// File: rtl/mc_alu_pkg.sv
// mc_alu shared types: opcode enum, FSM state, latency constant.
// Optional divider feature selected by macro MC_ALU_DIV_EN.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSB = 4'd0,
    OP_SLTU  = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_PASSA = 4'd4,
    OP_MUL   = 4'd5,
    OP_EQ    = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_SLT   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_REMU  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Accept-to-out_valid latency of the single-cycle ops.
  localparam int ALU_LAT_1 = 1;

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative unit: shift-add multiplier and (MC_ALU_DIV_EN) restoring
// divider. Ports: clk, rst_n, start_i, a_i, b_i, last_o, mul_o, quo_o, rem_o.
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
`ifdef MC_ALU_DIV_EN
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
`endif
  output logic [WIDTH-1:0] mul_o
);

  localparam int CW = $clog2(WIDTH);

  logic          busy_q;
  logic [CW-1:0] cnt_q;

  // last_o marks the edge that performs the final iteration;
  // the *_o results are the values after that iteration.
  assign last_o = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !last_o;
      cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

  logic [WIDTH-1:0] acc_q, mcd_q, mpl_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d = acc_q + (mpl_q[0] ? mcd_q : '0);
  assign mul_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mcd_q <= '0;
      mpl_q <= '0;
    end else if (start_i) begin
      acc_q <= '0;
      mcd_q <= a_i;
      mpl_q <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      mcd_q <= mcd_q << 1;
      mpl_q <= mpl_q >> 1;
    end
  end

`ifdef MC_ALU_DIV_EN
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   rsh, dif;

  // Divisor 0 always subtracts: quotient all-ones, remainder = a.
  always_comb begin
    rsh   = {rem_q, quo_q[WIDTH-1]};
    dif   = rsh - {1'b0, dvs_q};
    rem_d = rsh[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!dif[WIDTH]) begin
      rem_d = dif[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign quo_o = quo_d;
  assign rem_o = rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= a_i;
      dvs_q <= b_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
`endif

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU top: FSM, single-cycle datapath, output registers.
// Ports: valid/ready in (a,b,op), valid/ready out (y,zero,carry,ovf,err).
// Macro MC_ALU_DIV_EN enables DIVU/REMU; otherwise they are illegal.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int OPX = (OP_W > 4) ? OP_W : 4;

  logic [OPX-1:0] op_x;
  logic [3:0]     code;
  logic           hi_nz;

  assign op_x  = OPX'(op);
  assign code  = op_x[3:0];
  assign hi_nz = |(op_x >> 4);

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] r_y;
  logic             r_z, r_c, r_v, r_e, r_eq, r_iter;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    r_y    = '0;
    r_c    = 1'b0;
    r_v    = 1'b0;
    r_e    = 1'b0;
    r_eq   = 1'b0;
    r_iter = 1'b0;
    if (hi_nz) begin
      r_e = 1'b1;
    end else begin
      case (code)
        OP_PASSB: r_y = b;
        OP_SLTU:  r_y = {{(WIDTH-1){1'b0}}, a < b};
        OP_ADD: begin
          r_y = add_w[WIDTH-1:0];
          r_c = add_w[WIDTH];
          r_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                (add_w[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          r_y = sub_w[WIDTH-1:0];
          r_c = sub_w[WIDTH];
          r_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                (sub_w[WIDTH-1] != a[WIDTH-1]);
        end
        OP_PASSA: r_y = a;
        OP_MUL:   r_iter = 1'b1;
        OP_EQ:    r_eq = 1'b1;
        OP_AND:   r_y = a & b;
        OP_OR:    r_y = a | b;
        OP_XOR:   r_y = a ^ b;
        OP_SLT:   r_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef MC_ALU_DIV_EN
        OP_DIVU:  r_iter = 1'b1;
        OP_REMU:  r_iter = 1'b1;
`endif
        default:  r_e = 1'b1;
      endcase
    end
    r_z = r_eq ? (a == b) : (r_y == '0);
  end

  logic             start, last;
  logic [WIDTH-1:0] mul_r, it_y;
  logic             it_e;

`ifdef MC_ALU_DIV_EN
  logic [WIDTH-1:0] quo_r, rem_r;
  op_e              kind_q, kind_d;
  logic             bz_q, bz_d;
`endif

  mc_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .last_o  (last),
`ifdef MC_ALU_DIV_EN
    .quo_o   (quo_r),
    .rem_o   (rem_r),
`endif
    .mul_o   (mul_r)
  );

  always_comb begin
    it_y = mul_r;
    it_e = 1'b0;
`ifdef MC_ALU_DIV_EN
    if (kind_q == OP_DIVU) it_y = quo_r;
    if (kind_q == OP_REMU) it_y = rem_r;
    it_e = (kind_q != OP_MUL) && bz_q;
`endif
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, c_q, c_d;
  logic             v_q, v_d, e_q, e_d;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    e_d     = e_q;
    start   = 1'b0;
`ifdef MC_ALU_DIV_EN
    kind_d  = kind_q;
    bz_d    = bz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (r_iter) begin
            start   = 1'b1;
            state_d = S_BUSY;
`ifdef MC_ALU_DIV_EN
            kind_d  = op_e'(code);
            bz_d    = (b == '0);
`endif
          end else begin
            state_d = S_DONE;
            y_d     = r_y;
            z_d     = r_z;
            c_d     = r_c;
            v_d     = r_v;
            e_d     = r_e;
          end
        end
      end
      S_BUSY: begin
        if (last) begin
          state_d = S_DONE;
          y_d     = it_y;
          z_d     = (it_y == '0);
          c_d     = 1'b0;
          v_d     = 1'b0;
          e_d     = it_e;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      e_q     <= 1'b0;
`ifdef MC_ALU_DIV_EN
      kind_q  <= OP_PASSB;
      bz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      e_q     <= e_d;
`ifdef MC_ALU_DIV_EN
      kind_q  <= kind_d;
      bz_q    <= bz_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign ovf       = v_q;
  assign err       = e_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed testbench for mc_alu (WIDTH=32).
// Honors MC_ALU_DIV_EN for the divider expectations.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        zero, carry, ovf, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  // Issue one op from IDLE (#1 after an edge); return cycles to out_valid.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] z, output int lat);
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL rst_y got %h exp 0", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {zero, carry, ovf, err}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid2 got %b exp 0", out_valid); end
  endtask

  task automatic test_add_sub();
    int lat;
    run_op(4'd2, 32'h7FFF_FFFF, 32'h1, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d exp 1", lat); end
    checks++; if (y !== 32'h8000_0000) begin errors++; $display("FAIL add_y got %h exp 80000000", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b0010) begin errors++; $display("FAIL add_flags zcve got %b exp 0010", {zero, carry, ovf, err}); end
    release_out();
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, lat);
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL add_wrap_y got %h exp 0", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b1100) begin errors++; $display("FAIL add_wrap_flags got %b exp 1100", {zero, carry, ovf, err}); end
    release_out();
    run_op(4'd3, 32'd5, 32'd5, lat);
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL sub_eq_y got %h exp 0", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b1100) begin errors++; $display("FAIL sub_eq_flags got %b exp 1100", {zero, carry, ovf, err}); end
    release_out();
    run_op(4'd3, 32'd3, 32'd5, lat);
    checks++; if (y !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg_y got %h exp fffffffe", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b0000) begin errors++; $display("FAIL sub_neg_flags got %b exp 0000", {zero, carry, ovf, err}); end
    release_out();
    run_op(4'd3, 32'h8000_0000, 32'h1, lat);
    checks++; if (y !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_ovf_y got %h exp 7fffffff", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b0110) begin errors++; $display("FAIL sub_ovf_flags got %b exp 0110", {zero, carry, ovf, err}); end
    release_out();
    run_op(4'd6, 32'd9, 32'd9, lat);
    checks++; if ({y, zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL eq_same got y=%h z=%b exp y=0 z=1", y, zero); end
    release_out();
    run_op(4'd6, 32'd9, 32'd8, lat);
    checks++; if ({y, zero} !== {32'h0, 1'b0}) begin errors++; $display("FAIL eq_diff got y=%h z=%b exp y=0 z=0", y, zero); end
    release_out();
  endtask

  task automatic test_logic();
    logic [3:0]  ops [9] = '{4'd7, 4'd8, 4'd9, 4'd4, 4'd0, 4'd10, 4'd1, 4'd15, 4'd13};
    logic [31:0] xa  [9] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF,
                             32'hF0F0_00FF, 32'hF0F0_00FF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h1234, 32'h1234};
    logic [31:0] xb  [9] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                             32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h1,
                             32'h1, 32'h5678, 32'h5678};
    logic [31:0] ey  [9] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0,
                             32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h1,
                             32'h0, 32'h0, 32'h0};
    logic [3:0]  ef  [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b1000, 4'b1001, 4'b1001};
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], xa[i], xb[i], lat);
      checks++;
      if (lat !== 1 || y !== ey[i] || {zero, carry, ovf, err} !== ef[i]) begin
        errors++;
        $display("FAIL logic_op%0d got lat=%0d y=%h f=%b exp lat=1 y=%h f=%b",
                 ops[i], lat, y, {zero, carry, ovf, err}, ey[i], ef[i]);
      end
      release_out();
    end
  endtask

  task automatic test_mul();
    int lat;
    op = 4'd5; a = 32'h0001_0000; b = 32'h0001_0001; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep presenting a different op while busy; it must be ignored.
    op = 4'd2; a = 32'd1; b = 32'd1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_lat got %0d exp 33", lat); end
    checks++; if (y !== 32'h0001_0000) begin errors++; $display("FAIL mul_y got %h exp 00010000", y); end
    checks++; if ({zero, carry, ovf, err} !== 4'b0000) begin errors++; $display("FAIL mul_flags got %b exp 0000", {zero, carry, ovf, err}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_done_ready got %b exp 0", in_ready); end
    a = 32'hDEAD_BEEF; b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y !== 32'h0001_0000) begin
        errors++;
        $display("FAIL mul_hold%0d got v=%b y=%h exp v=1 y=00010000", i, out_valid, y);
      end
    end
    release_out();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL mul_release got %b exp 10", {in_ready, out_valid}); end
    run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (y !== 32'h1) begin errors++; $display("FAIL mul_max got %h exp 1", y); end
    release_out();
    run_op(4'd5, 32'h1234_5678, 32'h10, lat);
    checks++; if (y !== 32'h2345_6780) begin errors++; $display("FAIL mul_shift got %h exp 23456780", y); end
    release_out();
  endtask

  task automatic test_div();
    int lat;
`ifdef MC_ALU_DIV_EN
    run_op(4'd11, 32'd100, 32'd7, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_lat got %0d exp 33", lat); end
    checks++; if ({y, err} !== {32'd14, 1'b0}) begin errors++; $display("FAIL divu_y got %h e=%b exp 0000000e e=0", y, err); end
    release_out();
    run_op(4'd12, 32'd100, 32'd7, lat);
    checks++; if ({y, err} !== {32'd2, 1'b0}) begin errors++; $display("FAIL remu_y got %h e=%b exp 2 e=0", y, err); end
    release_out();
    run_op(4'd11, 32'd100, 32'd0, lat);
    checks++; if ({y, err} !== {32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL divu_z got %h e=%b exp ffffffff e=1", y, err); end
    release_out();
    run_op(4'd12, 32'd5, 32'd0, lat);
    checks++; if ({y, err} !== {32'd5, 1'b1}) begin errors++; $display("FAIL remu_z got %h e=%b exp 5 e=1", y, err); end
    release_out();
`else
    run_op(4'd11, 32'd100, 32'd7, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divu_off_lat got %0d exp 1", lat); end
    checks++; if ({y, err} !== {32'h0, 1'b1}) begin errors++; $display("FAIL divu_off got %h e=%b exp 0 e=1", y, err); end
    release_out();
    run_op(4'd12, 32'd100, 32'd7, lat);
    checks++; if ({y, err} !== {32'h0, 1'b1}) begin errors++; $display("FAIL remu_off got %h e=%b exp 0 e=1", y, err); end
    release_out();
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    op = 4'd2; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready, y} !== {2'b10, 32'd30}) begin errors++; $display("FAIL b2b_first got v=%b r=%b y=%h exp v=1 r=0 y=1e", out_valid, in_ready, y); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_gap got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got v=%b exp 1", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got r=%b exp 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen = 1'b0;
    op = 4'd5; a = 32'd3; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, y} !== {1'b0, 32'h0}) begin errors++; $display("FAIL abort_rst got v=%b y=%h exp v=0 y=0", out_valid, y); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_novalid got %b exp 0", seen); end
    run_op(4'd2, 32'd2, 32'd3, lat);
    checks++; if ({lat == 1, y} !== {1'b1, 32'd5}) begin errors++; $display("FAIL abort_add got lat=%0d y=%h exp lat=1 y=5", lat, y); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
